// File: rtl/regfile_arbiter_if.sv
// Request/response bundle for the two requesters of regfile_arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface regfile_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Handshake: a request transfers in any cycle where reqN_valid & reqN_ready.
    // reqN_ready may depend combinationally on both valids, so valid must never
    // depend on ready. A stalled requester holds its fields stable. Responses
    // have no backpressure.
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr1;
    logic [ADDR_W-1:0] req0_addr2;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_src1;
    logic [DATA_W-1:0] rsp0_src2;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr1;
    logic [ADDR_W-1:0] req1_addr2;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_src1;
    logic [DATA_W-1:0] rsp1_src2;

    modport master (
        output req0_valid, req0_write, req0_addr1, req0_addr2, req0_wdata,
        output req1_valid, req1_write, req1_addr1, req1_addr2, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_src1, rsp0_src2,
        input  req1_ready, rsp1_valid, rsp1_src1, rsp1_src2
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr1, req0_addr2, req0_wdata,
        input  req1_valid, req1_write, req1_addr1, req1_addr2, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_src1, rsp0_src2,
        output req1_ready, rsp1_valid, rsp1_src1, rsp1_src2
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 2R1W register file: read/write pairs are
// granted together, same-type conflicts are serialised round-robin.
module regfile_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    regfile_arbiter_if.slave  req,
    output logic              rf_enable,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_src1_addr,
    output logic [ADDR_W-1:0] rf_src2_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_src2,
    output logic              dbg_prio
);

    logic              prio;
    logic              mixed;
    logic              contend;
    logic              gnt0;
    logic              gnt1;
    logic              rd0;
    logic              rd1;
    logic              wr_any;
    logic [ADDR_W-1:0] src1_a;
    logic [ADDR_W-1:0] src2_a;
    logic [ADDR_W-1:0] wr_a;
    logic [DATA_W-1:0] wr_d;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src2;

    // Grants are computed without reset; reset only gates what leaves the block.
    always_comb begin
        mixed   = req.req0_write ^ req.req1_write;
        contend = req.req0_valid & req.req1_valid & ~mixed;
        gnt0    = req.req0_valid & (~req.req1_valid | mixed | ~prio);
        gnt1    = req.req1_valid & (~req.req0_valid | mixed | prio);
        rd0     = gnt0 & ~req.req0_write;
        rd1     = gnt1 & ~req.req1_write;
        wr_any  = (gnt0 & req.req0_write) | (gnt1 & req.req1_write);

        src1_a = '0;
        src2_a = '0;
        if (rd0) begin
            src1_a = req.req0_addr1;
            src2_a = req.req0_addr2;
        end else if (rd1) begin
            src1_a = req.req1_addr1;
            src2_a = req.req1_addr2;
        end

        wr_a = '0;
        wr_d = '0;
        if (gnt0 & req.req0_write) begin
            wr_a = req.req0_addr1;
            wr_d = req.req0_wdata;
        end else if (gnt1 & req.req1_write) begin
            wr_a = req.req1_addr1;
            wr_d = req.req1_wdata;
        end

        // Same-cycle write bypasses the regfile, which only commits at the edge.
        sel_src1 = (wr_any && src1_a == wr_a) ? wr_d : rf_src1;
        sel_src2 = (wr_any && src2_a == wr_a) ? wr_d : rf_src2;
    end

    assign req.req0_ready = rst & gnt0;
    assign req.req1_ready = rst & gnt1;
    assign rf_enable      = rst & (gnt0 | gnt1);
    assign rf_write       = rst & wr_any;
    assign rf_src1_addr   = rst ? src1_a : '0;
    assign rf_src2_addr   = rst ? src2_a : '0;
    assign rf_write_addr  = rst ? wr_a : '0;
    assign rf_write_data  = rst ? wr_d : '0;
    assign dbg_prio       = prio;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio           <= 1'b0;
            req.rsp0_valid <= 1'b0;
            req.rsp0_src1  <= '0;
            req.rsp0_src2  <= '0;
            req.rsp1_valid <= 1'b0;
            req.rsp1_src1  <= '0;
            req.rsp1_src2  <= '0;
        end else begin
            // The loser of a same-type conflict wins next time.
            if (contend) prio <= ~prio;
            req.rsp0_valid <= rd0;
            req.rsp1_valid <= rd1;
            if (rd0) begin
                req.rsp0_src1 <= sel_src1;
                req.rsp0_src2 <= sel_src2;
            end
            if (rd1) begin
                req.rsp1_src1 <= sel_src1;
                req.rsp1_src2 <= sel_src2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model of grants, register contents and responses.
module tb_regfile_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              rf_enable;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_src1_addr;
    logic [ADDR_W-1:0] rf_src2_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_src1;
    logic [DATA_W-1:0] rf_src2;
    logic              dbg_prio;

    regfile_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (bus.slave),
        .rf_enable     (rf_enable),
        .rf_write      (rf_write),
        .rf_src1_addr  (rf_src1_addr),
        .rf_src2_addr  (rf_src2_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_src1       (rf_src1),
        .rf_src2       (rf_src2),
        .dbg_prio      (dbg_prio)
    );

    // External register file the arbiter drives.
    logic [DATA_W-1:0] rf_mem [64] = '{default: '0};
    assign rf_src1 = rf_mem[rf_src1_addr];
    assign rf_src2 = rf_mem[rf_src2_addr];
    always @(posedge clk) if (rf_enable && rf_write) rf_mem[rf_write_addr] <= rf_write_data;

    // ---------------- reference model / scoreboard ----------------
    int                checks = 0;
    int                errors = 0;
    bit                model_prio = 1'b0;
    logic [DATA_W-1:0] model_mem [64] = '{default: '0};
    logic [63:0]       exp0_q[$];
    logic [63:0]       exp1_q[$];
    logic [63:0]       last0 = '0;
    logic [63:0]       last1 = '0;
    bit                last_g0 = 1'b0;
    bit                last_g1 = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(bit v, bit w, logic [5:0] a1, logic [5:0] a2, logic [31:0] d);
        bus.req0_valid = v;
        bus.req0_write = w;
        bus.req0_addr1 = a1;
        bus.req0_addr2 = a2;
        bus.req0_wdata = d;
    endtask

    task automatic drive1(bit v, bit w, logic [5:0] a1, logic [5:0] a2, logic [31:0] d);
        bus.req1_valid = v;
        bus.req1_write = w;
        bus.req1_addr1 = a1;
        bus.req1_addr2 = a2;
        bus.req1_wdata = d;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 6'd0, 6'd0, 32'd0);
        drive1(1'b0, 1'b0, 6'd0, 6'd0, 32'd0);
    endtask

    // One clock cycle: inputs already driven at the falling edge.
    task automatic step(bit rst_after);
        bit v0, v1, w0, w1, e0, e1, contend, wr_any, rd_any;
        int rdr;
        logic [5:0]  wa, ra1, ra2;
        logic [31:0] wd, s1, s2;
        #1;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        w0 = bus.req0_write; w1 = bus.req1_write;
        contend = v0 && v1 && (w0 == w1);
        if (contend) begin
            e0 = (model_prio == 1'b0);
            e1 = (model_prio == 1'b1);
        end else begin
            e0 = v0;
            e1 = v1;
        end
        wr_any = (e0 && w0) || (e1 && w1);
        rd_any = (e0 && !w0) || (e1 && !w1);
        wa = '0; wd = '0;
        if (e0 && w0) begin wa = bus.req0_addr1; wd = bus.req0_wdata; end
        else if (e1 && w1) begin wa = bus.req1_addr1; wd = bus.req1_wdata; end
        ra1 = '0; ra2 = '0; rdr = -1;
        if (e0 && !w0) begin rdr = 0; ra1 = bus.req0_addr1; ra2 = bus.req0_addr2; end
        else if (e1 && !w1) begin rdr = 1; ra1 = bus.req1_addr1; ra2 = bus.req1_addr2; end

        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
        chk("prio", dbg_prio, model_prio);
        chk("rf_enable", rf_enable, e0 || e1);
        chk("rf_write", rf_write, wr_any);
        chk("rf_write_addr", rf_write_addr, wa);
        chk("rf_write_data", rf_write_data, wd);
        chk("rf_src1_addr", rf_src1_addr, ra1);
        chk("rf_src2_addr", rf_src2_addr, ra2);

        if (rd_any) begin
            s1 = (wr_any && ra1 == wa) ? wd : model_mem[ra1];
            s2 = (wr_any && ra2 == wa) ? wd : model_mem[ra2];
            if (rdr == 0) exp0_q.push_back({s1, s2});
            else          exp1_q.push_back({s1, s2});
        end

        @(posedge clk);
        if (wr_any) model_mem[wa] = wd;
        if (contend) model_prio = ~model_prio;
        last_g0 = e0;
        last_g1 = e1;
        if (rst_after) begin
            #1 rst = 1'b0;
            exp0_q.delete(); exp1_q.delete();
            model_prio = 1'b0;
            last0 = '0; last1 = '0;
            last_g0 = 1'b0; last_g1 = 1'b0;
        end
        #1;
        if (exp0_q.size() > 0) begin
            last0 = exp0_q.pop_front();
            chk("rsp0_valid", bus.rsp0_valid, 1'b1);
        end else chk("rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rsp0_data", {bus.rsp0_src1, bus.rsp0_src2}, last0);
        if (exp1_q.size() > 0) begin
            last1 = exp1_q.pop_front();
            chk("rsp1_valid", bus.rsp1_valid, 1'b1);
        end else chk("rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rsp1_data", {bus.rsp1_src1, bus.rsp1_src2}, last1);
        if (rst_after) begin
            chk("rst_req0_ready", bus.req0_ready, 1'b0);
            chk("rst_rf_enable", rf_enable, 1'b0);
            chk("rst_rf_src1_addr", rf_src1_addr, '0);
            chk("rst_prio", dbg_prio, 1'b0);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        drive0(1'b1, 1'b1, 6'd5, 6'd0, 32'h1234_5678);
        #2;
        chk("reset_req0_ready", bus.req0_ready, 1'b0);
        chk("reset_rf_enable", rf_enable, 1'b0);
        chk("reset_rf_write", rf_write, 1'b0);
        chk("reset_rf_write_data", rf_write_data, '0);
        chk("reset_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("reset_rsp0_data", {bus.rsp0_src1, bus.rsp0_src2}, '0);
        chk("reset_prio", dbg_prio, 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b1;

        // Write then read back with an unwritten second operand.
        drive0(1'b1, 1'b1, 6'd5, 6'd0, 32'hffff_0000);
        step(1'b0);
        drive0(1'b1, 1'b0, 6'd5, 6'd33, 32'd0);
        step(1'b0);
        chk("tp_rsp0_first_read", {bus.rsp0_src1, bus.rsp0_src2}, 64'hffff0000_00000000);
        idle();
        step(1'b0);
        chk("tp_rsp0_single_pulse", bus.rsp0_valid, 1'b0);

        // Write/write contention alternates.
        drive0(1'b1, 1'b1, 6'd15, 6'd0, 32'hffff_0001);
        drive1(1'b1, 1'b1, 6'd24, 6'd0, 32'hffff_0002);
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("tp_mem15", rf_mem[15], 32'hffff_0001);
        chk("tp_mem24", rf_mem[24], 32'hffff_0002);

        // Mixed write/read in one cycle with forwarding on src1.
        drive0(1'b1, 1'b1, 6'd44, 6'd0, 32'hffff_0005);
        drive1(1'b1, 1'b0, 6'd44, 6'd5, 32'd0);
        step(1'b0);
        chk("tp_rsp1_forward", {bus.rsp1_src1, bus.rsp1_src2}, 64'hffff0005_ffff0000);

        // Read/read contention for 4 cycles.
        drive0(1'b1, 1'b0, 6'd15, 6'd24, 32'd0);
        drive1(1'b1, 1'b0, 6'd44, 6'd5, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0);

        // Read grant to req0 (prio becomes 1), then reset in the response cycle.
        step(1'b1);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive1(1'b1, 1'b0, 6'd44, 6'd15, 32'd0);
        step(1'b0);
        chk("tp_rsp1_after_reset", {bus.rsp1_src1, bus.rsp1_src2}, 64'hffff0005_ffff0001);

        // Back-to-back writes to one address, then read it twice.
        idle();
        drive0(1'b1, 1'b1, 6'd63, 6'd0, 32'hffff_0006);
        step(1'b0);
        drive0(1'b1, 1'b1, 6'd63, 6'd0, 32'hffff_ffff);
        step(1'b0);
        drive0(1'b1, 1'b0, 6'd63, 6'd63, 32'd0);
        step(1'b0);
        chk("tp_rsp0_last_write", {bus.rsp0_src1, bus.rsp0_src2}, 64'hffffffff_ffffffff);

        // Random traffic; stalled requesters hold their request.
        idle();
        for (int i = 0; i < 400; i++) begin
            if (!(bus.req0_valid && !last_g0))
                drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), $urandom);
            if (!(bus.req1_valid && !last_g1))
                drive1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), $urandom);
            step(1'b0);
        end
        idle();
        step(1'b0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
